// File: rtl/dnn_pkg.sv
// Shared opcode encoding, phase-counter constants and small decode helpers
// for the weight-broadcast convolution engine.
package dnn_pkg;

  localparam int X_DIM_DEF            = 4;
  localparam int Y_DIM_DEF            = 4;
  localparam int DATA_WIDTH_DEF       = 8;
  localparam int FIFO_DEPTH_WIDTH_DEF = 2;

  // Phase counter is wide enough for the longest opcode period (3 cycles)
  localparam int PHASE_W = 2;

  localparam logic [PHASE_W-1:0] PERIOD_SRAM2BUF = 2'd2;
  localparam logic [PHASE_W-1:0] PERIOD_BUF2PE   = 2'd3;
  localparam logic [PHASE_W-1:0] PERIOD_SINGLE   = 2'd1;
  localparam logic [PHASE_W-1:0] PUSH_PHASE      = 2'd1;
  localparam logic [PHASE_W-1:0] POP_PHASE       = 2'd2;

  typedef enum logic [2:0] {
    OP_NONE             = 3'b000,
    OP_DEFAULT          = 3'b001,
    OP_LD_WT_SRAM2PE    = 3'b010,
    OP_LD_IF_SRAM2BUF   = 3'b011,
    OP_LD_IF_BUF2PE     = 3'b100,
    OP_DNNEXEC          = 3'b101,
    OP_UNLD_OF_PE2BUF   = 3'b110,
    OP_UNLD_OF_BUF2SRAM = 3'b111
  } opcode_t;

  // Code 000 behaves exactly like DEFAULT, so fold it in before edge detection
  // so that 000 <-> 001 transitions are not seen as opcode changes.
  function automatic opcode_t decode_op(input logic [2:0] code);
    opcode_t op;
    case (code)
      3'b000:  op = OP_DEFAULT;
      3'b001:  op = OP_DEFAULT;
      3'b010:  op = OP_LD_WT_SRAM2PE;
      3'b011:  op = OP_LD_IF_SRAM2BUF;
      3'b100:  op = OP_LD_IF_BUF2PE;
      3'b101:  op = OP_DNNEXEC;
      3'b110:  op = OP_UNLD_OF_PE2BUF;
      3'b111:  op = OP_UNLD_OF_BUF2SRAM;
      default: op = OP_DEFAULT;
    endcase
    return op;
  endfunction

  // Number of cycles after which the phase counter wraps for a held opcode
  function automatic logic [PHASE_W-1:0] op_period(input opcode_t op);
    logic [PHASE_W-1:0] p;
    case (op)
      OP_LD_IF_SRAM2BUF: p = PERIOD_SRAM2BUF;
      OP_LD_IF_BUF2PE:   p = PERIOD_BUF2PE;
      default:           p = PERIOD_SINGLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/dnn_pe.sv
// Single processing element: unsigned multiply of activation by the
// broadcast weight, accumulated into a wrapping 2*DATA_WIDTH register.
module dnn_pe
  import dnn_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [DATA_WIDTH-1:0]     act_in,
  input  logic [DATA_WIDTH-1:0]     wt,
  output logic [2*DATA_WIDTH-1:0]   acc_out
);

  logic [2*DATA_WIDTH-1:0] acc_r;
  logic [2*DATA_WIDTH-1:0] prod_s;

  // Full-width product so 255*255 does not truncate before accumulation
  always_comb begin
    prod_s = (2*DATA_WIDTH)'(act_in) * (2*DATA_WIDTH)'(wt);
  end

  // Accumulator: only an asynchronous reset clears it; sum wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= acc_r + prod_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc_out = acc_r;

endmodule

// File: rtl/dnn_hw_top.sv
// Weight-broadcast convolution engine: per-lane activation FIFOs, a shift
// chain of activation registers feeding an X_DIM x Y_DIM MAC array, and an
// opcode-driven phase counter that paces pushes, pops and the single MAC.
module dnn_hw_top
  import dnn_pkg::*;
#(
  parameter int X_DIM            = X_DIM_DEF,
  parameter int Y_DIM            = Y_DIM_DEF,
  parameter int DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH_WIDTH = FIFO_DEPTH_WIDTH_DEF
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  output logic                                          done,
  input  logic [2:0]                                    fsm_input,
  input  logic [Y_DIM-1:0][DATA_WIDTH-1:0]              sram_if_in,
  input  logic [DATA_WIDTH-1:0]                         sram_wt_in,
  output logic [X_DIM-1:0][Y_DIM-1:0][2*DATA_WIDTH-1:0] sram_of_out
);

  localparam int            DEPTH   = 1 << FIFO_DEPTH_WIDTH;
  localparam int            PTR_W   = FIFO_DEPTH_WIDTH + 1;
  localparam logic [PTR_W-1:0] DEPTH_V = PTR_W'(DEPTH);

  // Opcode tracking and phase
  opcode_t            op_s;
  opcode_t            prev_op_r;
  logic               op_change_s;
  logic [PHASE_W-1:0] phase_r;
  logic [PHASE_W-1:0] phase_s;
  logic [PHASE_W-1:0] phase_next_s;
  logic [PHASE_W-1:0] phase_last_s;

  // Action strobes
  logic push_s;
  logic pop_s;
  logic exec_s;
  logic unld_s;
  logic wt_ld_s;

  // FIFO storage; all lanes move together so one pointer pair serves all
  logic [DATA_WIDTH-1:0] fifo_mem_r [Y_DIM][DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      fill_s;
  logic                  full_s;
  logic                  empty_s;
  logic [Y_DIM-1:0][DATA_WIDTH-1:0] pop_row_s;

  // PE-side state
  logic [DATA_WIDTH-1:0]                         wt_r;
  logic [X_DIM-1:0][Y_DIM-1:0][DATA_WIDTH-1:0]   act_r;
  logic [X_DIM-1:0][Y_DIM-1:0][2*DATA_WIDTH-1:0] acc_s;
  logic                                          done_r;
  logic [X_DIM-1:0][Y_DIM-1:0][2*DATA_WIDTH-1:0] of_r;

  // Decode opcode, detect changes and derive the phase seen this cycle
  always_comb begin
    op_s         = decode_op(fsm_input);
    op_change_s  = (op_s != prev_op_r);
    if (op_change_s) begin
      phase_s = '0;
    end else begin
      phase_s = phase_r;
    end
    phase_last_s = op_period(op_s) - 2'd1;
    if (phase_s >= phase_last_s) begin
      phase_next_s = '0;
    end else begin
      phase_next_s = phase_s + 2'd1;
    end
  end

  // FIFO occupancy from the extra-MSB pointer scheme
  always_comb begin
    fill_s  = wr_ptr_r - rd_ptr_r;
    full_s  = (fill_s == DEPTH_V);
    empty_s = (fill_s == '0);
    for (int y = 0; y < Y_DIM; y++) begin
      pop_row_s[y] = fifo_mem_r[y][rd_ptr_r[FIFO_DEPTH_WIDTH-1:0]];
    end
  end

  // Action strobes; start suppresses every opcode action in its cycle
  always_comb begin
    push_s  = !start && (op_s == OP_LD_IF_SRAM2BUF) && (phase_s == PUSH_PHASE) && !full_s;
    pop_s   = !start && (op_s == OP_LD_IF_BUF2PE)   && (phase_s == POP_PHASE)  && !empty_s;
    exec_s  = !start && (op_s == OP_DNNEXEC)        && op_change_s;
    unld_s  = !start && (op_s == OP_UNLD_OF_PE2BUF);
    wt_ld_s = !start && (op_s == OP_LD_WT_SRAM2PE);
  end

  // Opcode history and free-running phase counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_op_r <= OP_DEFAULT;
      phase_r   <= '0;
    end else if (start) begin
      prev_op_r <= op_s;
      phase_r   <= '0;
    end else begin
      prev_op_r <= op_s;
      phase_r   <= phase_next_s;
    end
  end

  // FIFO pointers: start empties every lane
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (start) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // FIFO storage write on accepted push
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int y = 0; y < Y_DIM; y++) begin
        for (int d = 0; d < DEPTH; d++) begin
          fifo_mem_r[y][d] <= '0;
        end
      end
    end else if (push_s) begin
      for (int y = 0; y < Y_DIM; y++) begin
        fifo_mem_r[y][wr_ptr_r[FIFO_DEPTH_WIDTH-1:0]] <= sram_if_in[y];
      end
    end else begin
      fifo_mem_r <= fifo_mem_r;
    end
  end

  // Broadcast weight register; survives start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wt_r <= '0;
    end else if (wt_ld_s) begin
      wt_r <= sram_wt_in;
    end else begin
      wt_r <= wt_r;
    end
  end

  // Activation shift chain: newest row enters at column X_DIM-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_r <= '0;
    end else if (start) begin
      act_r <= '0;
    end else if (pop_s) begin
      for (int x = 0; x < X_DIM - 1; x++) begin
        act_r[x] <= act_r[x+1];
      end
      act_r[X_DIM-1] <= pop_row_s;
    end else begin
      act_r <= act_r;
    end
  end

  // MAC array
  for (genvar gx = 0; gx < X_DIM; gx++) begin : g_col
    for (genvar gy = 0; gy < Y_DIM; gy++) begin : g_row
      dnn_pe #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_pe (
        .clk     (clk),
        .rst     (rst),
        .en      (exec_s),
        .act_in  (act_r[gx][gy]),
        .wt      (wt_r),
        .acc_out (acc_s[gx][gy])
      );
    end
  end

  // Output snapshot and done pulse on the first unload cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      of_r   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= unld_s && op_change_s;
      if (unld_s) begin
        of_r <= acc_s;
      end else begin
        of_r <= of_r;
      end
    end
  end

  assign sram_of_out = of_r;
  assign done        = done_r;

endmodule

// File: tb/tb_dnn_hw_top.sv
// Self-checking bench for dnn_hw_top: transaction-level reference model
// (row queue, activation matrix, integer accumulators) against the DUT.
module tb_dnn_hw_top;
  import dnn_pkg::*;

  localparam int XD = 4;
  localparam int YD = 4;
  localparam int DW = 8;
  localparam int FD = 4;

  typedef logic [YD-1:0][DW-1:0] row_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic done;
  logic [2:0] fsm_input;
  row_t sram_if_in;
  logic [DW-1:0] sram_wt_in;
  logic [XD-1:0][YD-1:0][2*DW-1:0] sram_of_out;

  always #5 clk = ~clk;

  dnn_hw_top #(
    .X_DIM(XD), .Y_DIM(YD), .DATA_WIDTH(DW), .FIFO_DEPTH_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .fsm_input(fsm_input), .sram_if_in(sram_if_in),
    .sram_wt_in(sram_wt_in), .sram_of_out(sram_of_out)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int   m_acc [XD][YD];
  int   m_act [XD][YD];
  int   m_wt;
  row_t m_q[$];
  row_t rows_buf [8];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear_tap();
    m_q.delete();
    for (int x = 0; x < XD; x++)
      for (int y = 0; y < YD; y++)
        m_act[x][y] = 0;
  endtask

  task automatic step(input logic [2:0] op, input int cycles);
    fsm_input = op;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b0;
    start = 1'b0;
    fsm_input = OP_DEFAULT;
    model_clear_tap();
    m_wt = 0;
    for (int x = 0; x < XD; x++)
      for (int y = 0; y < YD; y++)
        m_acc[x][y] = 0;
    @(negedge clk);
    check_eq({tag, "_of_zero"}, 32'(sram_of_out != '0), 32'd0);
    check_eq({tag, "_done_low"}, 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input row_t r);
    fsm_input = OP_LD_IF_SRAM2BUF;
    sram_if_in = r;
    repeat (2) @(posedge clk);
    #1;
    if (m_q.size() < FD) m_q.push_back(r);
  endtask

  task automatic pop_row();
    row_t r;
    fsm_input = OP_LD_IF_BUF2PE;
    repeat (3) @(posedge clk);
    #1;
    if (m_q.size() > 0) begin
      r = m_q.pop_front();
      for (int x = 0; x < XD - 1; x++)
        for (int y = 0; y < YD; y++)
          m_act[x][y] = m_act[x+1][y];
      for (int y = 0; y < YD; y++)
        m_act[XD-1][y] = int'(r[y]);
    end
  endtask

  task automatic exec_tap();
    step(OP_DEFAULT, 1);
    step(OP_DNNEXEC, 3);
    for (int x = 0; x < XD; x++)
      for (int y = 0; y < YD; y++)
        m_acc[x][y] = (m_acc[x][y] + m_wt * m_act[x][y]) % 65536;
  endtask

  task automatic run_tap(input int w, input int npush, input int npop, input bit do_exec);
    start = 1'b1;
    fsm_input = OP_DEFAULT;
    @(posedge clk);
    #1;
    start = 1'b0;
    model_clear_tap();
    sram_wt_in = DW'(w);
    step(OP_LD_WT_SRAM2PE, 2);
    m_wt = w;
    step(OP_DEFAULT, 1);
    for (int i = 0; i < npush; i++) push_row(rows_buf[i]);
    step(OP_DEFAULT, 1);
    for (int i = 0; i < npop; i++) pop_row();
    if (do_exec) exec_tap();
  endtask

  task automatic unload_check(input string tag);
    int pulses;
    pulses = 0;
    step(OP_DEFAULT, 1);
    fsm_input = OP_UNLD_OF_PE2BUF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) pulses++;
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_done_pulses"}, 32'(pulses), 32'd1);
    for (int x = 0; x < XD; x++)
      for (int y = 0; y < YD; y++)
        check_eq($sformatf("%s_of[%0d][%0d]", tag, x, y),
                 32'(sram_of_out[x][y]), 32'(m_acc[x][y]));
    step(OP_DEFAULT, 1);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    fsm_input = OP_DEFAULT;
    sram_if_in = '0;
    sram_wt_in = '0;
    apply_reset("reset");

    // Single tap with 5 rows offered (only 4 fit), weight 2
    for (int r = 0; r < 5; r++)
      for (int y = 0; y < YD; y++)
        rows_buf[r][y] = DW'(10 * r + y);
    run_tap(2, 5, 4, 1'b1);
    unload_check("tap1");
    check_eq("tap1_of32", 32'(sram_of_out[3][2]), 32'd64);

    // Second tap accumulates with weight 3
    run_tap(3, 5, 4, 1'b1);
    unload_check("tap2");
    check_eq("tap2_of32", 32'(sram_of_out[3][2]), 32'd160);

    // FIFO overflow and pop-from-empty with random rows
    for (int r = 0; r < 6; r++)
      for (int y = 0; y < YD; y++)
        rows_buf[r][y] = DW'($urandom_range(0, 255));
    run_tap($urandom_range(0, 255), 6, 5, 1'b1);
    unload_check("ovf");

    // Accumulator wrap: 255*255 twice
    apply_reset("rst_wrap");
    for (int r = 0; r < 4; r++)
      for (int y = 0; y < YD; y++)
        rows_buf[r][y] = 8'd255;
    run_tap(255, 4, 4, 1'b1);
    run_tap(255, 4, 4, 1'b1);
    unload_check("wrap");
    check_eq("wrap_of00", 32'(sram_of_out[0][0]), 32'd64514);

    // Randomized taps with varying push/pop counts
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < 6; r++)
        for (int y = 0; y < YD; y++)
          rows_buf[r][y] = DW'($urandom_range(0, 255));
      run_tap($urandom_range(0, 255), $urandom_range(1, 6), $urandom_range(1, 5), 1'b1);
      unload_check($sformatf("rnd%0d", t));
    end

    // Reset in the middle of DNNEXEC clears accumulators before unload
    run_tap(7, 4, 4, 1'b0);
    fsm_input = OP_DNNEXEC;
    @(posedge clk);
    #1;
    apply_reset("rst_exec");
    unload_check("post_rst");
    check_eq("post_rst_of32", 32'(sram_of_out[3][2]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
